stage_phase_accumulate: RTL and testbench

- Pipeline stage directly downstream of the modulation stage.
- Keeps a per-voice-operator phase accumulator and advances it by a configured phase step on each valid slot.
- Adds the incoming modulation phase and an optional self-feedback term.
- Emits the final 16-bit operator phase to the waveform lookup stage, passing the voice operator ID and algorithm word alongside.

---
 rtl/stage_phase_accumulate_pkg.sv | 26 ++
 rtl/phase_accumulator_ram.sv | 41 ++++
 rtl/stage_phase_accumulate.sv | 133 +++++++++++++
 tb/tb_stage_phase_accumulate.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stage_phase_accumulate_pkg.sv
// Shared types for the operator phase pipeline: voice operator IDs, algorithm
// words, feedback levels and the self-feedback scaling helper.
package stage_phase_accumulate_pkg;

    localparam int NUM_VOICE_OPERATORS = 32;
    localparam int VOP_WIDTH           = $clog2(NUM_VOICE_OPERATORS);
    localparam int FB_MAX_SHIFT        = 9;

    typedef logic [VOP_WIDTH-1:0] VoiceOperatorID_t;
    typedef logic [7:0]           AlgorithmWord_t;
    typedef logic [2:0]           FeedbackLevel_t;

    // Average-ish of the last two outputs, scaled by level; level 0 mutes feedback.
    function automatic logic [15:0] feedback_term(
        input logic [15:0]    fb0,
        input logic [15:0]    fb1,
        input FeedbackLevel_t level
    );
        logic signed [16:0] sum;
        logic signed [16:0] shifted;
        sum     = $signed({fb0[15], fb0}) + $signed({fb1[15], fb1});
        shifted = sum >>> (4'(FB_MAX_SHIFT) - 4'(level));
        return (level == '0) ? '0 : 16'(shifted);
    endfunction

endpackage

// File: rtl/phase_accumulator_ram.sv
// Per-operator phase accumulator store with write-back, note-on clear and
// forwarding of the value written this cycle to a same-address read.
module phase_accumulator_ram
    import stage_phase_accumulate_pkg::*;
#(
    parameter int ACC_WIDTH = 24
) (
    input  logic                 i_Clock,
    input  VoiceOperatorID_t     i_ReadAddr,
    output logic [ACC_WIDTH-1:0] o_ReadData,
    input  logic                 i_WriteEnable,
    input  VoiceOperatorID_t     i_WriteAddr,
    input  logic [ACC_WIDTH-1:0] i_WriteData,
    input  logic                 i_ResetEnable,
    input  VoiceOperatorID_t     i_ResetAddr
);

    logic [ACC_WIDTH-1:0] mem [NUM_VOICE_OPERATORS];
    logic                 reset_hits_write;
    logic [ACC_WIDTH-1:0] write_value;

    // A clear landing on the same entry as the write-back wins, and the forwarded value follows it.
    assign reset_hits_write = i_ResetEnable && (i_ResetAddr == i_WriteAddr);
    assign write_value      = reset_hits_write ? '0 : i_WriteData;

    always_ff @(posedge i_Clock) begin
        if (i_WriteEnable) begin
            mem[i_WriteAddr] <= i_WriteData;
        end
        if (i_ResetEnable) begin
            mem[i_ResetAddr] <= '0;
        end
        // A clear without a coinciding write-back is not forwarded: plain read-before-write.
        if (i_WriteEnable && (i_ReadAddr == i_WriteAddr)) begin
            o_ReadData <= write_value;
        end else begin
            o_ReadData <= mem[i_ReadAddr];
        end
    end

endmodule

// File: rtl/stage_phase_accumulate.sv
// Operator phase stage: advances per-operator accumulators, adds modulation
// and self-feedback, and hands a 16-bit phase to the waveform lookup 4 clocks later.
module stage_phase_accumulate
    import stage_phase_accumulate_pkg::*;
#(
    parameter int ACC_WIDTH  = 24,
    parameter int STEP_WIDTH = 20
) (
    input  logic                  i_Clock,
    input  logic                  i_Reset_n,
    input  logic                  i_Valid,
    input  logic [15:0]           i_ModulationPhase,
    input  VoiceOperatorID_t      i_VoiceOperator,
    input  AlgorithmWord_t        i_AlgorithmWord,
    output logic                  o_Valid,
    output logic [15:0]           o_Phase,
    output VoiceOperatorID_t      o_VoiceOperator,
    output AlgorithmWord_t        o_AlgorithmWord,
    input  logic                  i_PhaseStepWriteEnable,
    input  VoiceOperatorID_t      i_PhaseStepWriteAddr,
    input  logic [STEP_WIDTH-1:0] i_PhaseStepWriteData,
    input  logic                  i_FeedbackLevelWriteEnable,
    input  VoiceOperatorID_t      i_FeedbackLevelWriteAddr,
    input  FeedbackLevel_t        i_FeedbackLevelWriteData,
    input  logic                  i_PhaseResetEnable,
    input  VoiceOperatorID_t      i_PhaseResetAddr,
    input  logic                  i_FeedbackWriteEnable,
    input  VoiceOperatorID_t      i_FeedbackWriteAddr,
    input  logic [15:0]           i_FeedbackWriteData
);

    logic [STEP_WIDTH-1:0] step_mem  [NUM_VOICE_OPERATORS];
    FeedbackLevel_t        level_mem [NUM_VOICE_OPERATORS];
    logic [15:0]           fb0_mem   [NUM_VOICE_OPERATORS];
    logic [15:0]           fb1_mem   [NUM_VOICE_OPERATORS];

    logic                  s1_valid;
    logic [15:0]           s1_mod;
    VoiceOperatorID_t      s1_vop;
    AlgorithmWord_t        s1_alg;
    logic [ACC_WIDTH-1:0]  s1_acc;
    logic [STEP_WIDTH-1:0] s1_step;
    FeedbackLevel_t        s1_level;
    logic [15:0]           s1_fb0;
    logic [15:0]           s1_fb1;

    logic [ACC_WIDTH-1:0]  acc_next;
    logic [15:0]           fb_term;

    logic                  s2_valid;
    logic [15:0]           s2_carrier;
    logic [15:0]           s2_mod;
    logic [15:0]           s2_fb;
    VoiceOperatorID_t      s2_vop;
    AlgorithmWord_t        s2_alg;

    logic                  s3_valid;
    logic [15:0]           s3_phase;
    VoiceOperatorID_t      s3_vop;
    AlgorithmWord_t        s3_alg;

    // Configuration and feedback history stores; reads see the pre-write contents.
    always_ff @(posedge i_Clock) begin
        if (i_PhaseStepWriteEnable) begin
            step_mem[i_PhaseStepWriteAddr] <= i_PhaseStepWriteData;
        end
        if (i_FeedbackLevelWriteEnable) begin
            level_mem[i_FeedbackLevelWriteAddr] <= i_FeedbackLevelWriteData;
        end
        if (i_FeedbackWriteEnable) begin
            fb1_mem[i_FeedbackWriteAddr] <= fb0_mem[i_FeedbackWriteAddr];
            fb0_mem[i_FeedbackWriteAddr] <= i_FeedbackWriteData;
        end
        s1_step  <= step_mem[i_VoiceOperator];
        s1_level <= level_mem[i_VoiceOperator];
        s1_fb0   <= fb0_mem[i_VoiceOperator];
        s1_fb1   <= fb1_mem[i_VoiceOperator];
    end

    phase_accumulator_ram #(
        .ACC_WIDTH (ACC_WIDTH)
    ) u_acc_ram (
        .i_Clock       (i_Clock),
        .i_ReadAddr    (i_VoiceOperator),
        .o_ReadData    (s1_acc),
        .i_WriteEnable (s1_valid),
        .i_WriteAddr   (s1_vop),
        .i_WriteData   (acc_next),
        .i_ResetEnable (i_PhaseResetEnable),
        .i_ResetAddr   (i_PhaseResetAddr)
    );

    assign acc_next = s1_acc + {{(ACC_WIDTH-STEP_WIDTH){1'b0}}, s1_step};
    assign fb_term  = feedback_term(s1_fb0, s1_fb1, s1_level);

    always_ff @(posedge i_Clock) begin
        s1_mod     <= i_ModulationPhase;
        s1_vop     <= i_VoiceOperator;
        s1_alg     <= i_AlgorithmWord;

        s2_carrier <= acc_next[ACC_WIDTH-1 -: 16];
        s2_mod     <= s1_mod;
        s2_fb      <= fb_term;
        s2_vop     <= s1_vop;
        s2_alg     <= s1_alg;

        s3_phase   <= s2_carrier + s2_mod + s2_fb;
        s3_vop     <= s2_vop;
        s3_alg     <= s2_alg;
    end

    // Only the valid chain and the outputs are reset; clearing s1_valid also blocks flushed write-backs.
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            s1_valid        <= 1'b0;
            s2_valid        <= 1'b0;
            s3_valid        <= 1'b0;
            o_Valid         <= 1'b0;
            o_Phase         <= '0;
            o_VoiceOperator <= '0;
            o_AlgorithmWord <= '0;
        end else begin
            s1_valid        <= i_Valid;
            s2_valid        <= s1_valid;
            s3_valid        <= s2_valid;
            o_Valid         <= s3_valid;
            o_Phase         <= s3_phase;
            o_VoiceOperator <= s3_vop;
            o_AlgorithmWord <= s3_alg;
        end
    end

endmodule

// File: tb/tb_stage_phase_accumulate.sv
// Scoreboard bench: a sequential per-operator model predicts each slot's phase,
// and a negedge monitor checks value, IDs and 4-clock latency.
module tb_stage_phase_accumulate;
    import stage_phase_accumulate_pkg::*;

    localparam int NV = NUM_VOICE_OPERATORS;

    logic             i_Clock = 1'b0;
    logic             i_Reset_n = 1'b1;
    logic             i_Valid = 1'b0;
    logic [15:0]      i_ModulationPhase = '0;
    VoiceOperatorID_t i_VoiceOperator = '0;
    AlgorithmWord_t   i_AlgorithmWord = '0;
    logic             o_Valid;
    logic [15:0]      o_Phase;
    VoiceOperatorID_t o_VoiceOperator;
    AlgorithmWord_t   o_AlgorithmWord;
    logic             i_PhaseStepWriteEnable = 1'b0;
    VoiceOperatorID_t i_PhaseStepWriteAddr = '0;
    logic [19:0]      i_PhaseStepWriteData = '0;
    logic             i_FeedbackLevelWriteEnable = 1'b0;
    VoiceOperatorID_t i_FeedbackLevelWriteAddr = '0;
    FeedbackLevel_t   i_FeedbackLevelWriteData = '0;
    logic             i_PhaseResetEnable = 1'b0;
    VoiceOperatorID_t i_PhaseResetAddr = '0;
    logic             i_FeedbackWriteEnable = 1'b0;
    VoiceOperatorID_t i_FeedbackWriteAddr = '0;
    logic [15:0]      i_FeedbackWriteData = '0;

    stage_phase_accumulate #(.ACC_WIDTH(24), .STEP_WIDTH(20)) dut (
        .i_Clock                    (i_Clock),
        .i_Reset_n                  (i_Reset_n),
        .i_Valid                    (i_Valid),
        .i_ModulationPhase          (i_ModulationPhase),
        .i_VoiceOperator            (i_VoiceOperator),
        .i_AlgorithmWord            (i_AlgorithmWord),
        .o_Valid                    (o_Valid),
        .o_Phase                    (o_Phase),
        .o_VoiceOperator            (o_VoiceOperator),
        .o_AlgorithmWord            (o_AlgorithmWord),
        .i_PhaseStepWriteEnable     (i_PhaseStepWriteEnable),
        .i_PhaseStepWriteAddr       (i_PhaseStepWriteAddr),
        .i_PhaseStepWriteData       (i_PhaseStepWriteData),
        .i_FeedbackLevelWriteEnable (i_FeedbackLevelWriteEnable),
        .i_FeedbackLevelWriteAddr   (i_FeedbackLevelWriteAddr),
        .i_FeedbackLevelWriteData   (i_FeedbackLevelWriteData),
        .i_PhaseResetEnable         (i_PhaseResetEnable),
        .i_PhaseResetAddr           (i_PhaseResetAddr),
        .i_FeedbackWriteEnable      (i_FeedbackWriteEnable),
        .i_FeedbackWriteAddr        (i_FeedbackWriteAddr),
        .i_FeedbackWriteData        (i_FeedbackWriteData)
    );

    always #5 i_Clock = ~i_Clock;

    int cyc = 0;
    always @(posedge i_Clock) cyc++;

    typedef struct {
        logic [15:0]      phase;
        VoiceOperatorID_t vop;
        AlgorithmWord_t   alg;
        int               cyc;
    } exp_t;

    exp_t exp_q[$];
    int tests = 0;
    int fails = 0;

    // Reference state: plain per-operator arithmetic, no pipeline.
    int unsigned m_acc  [NV];
    int unsigned m_step [NV];
    int          m_level[NV];
    int          m_fb0  [NV];
    int          m_fb1  [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Applies this cycle's driven inputs to the model, then advances one clock.
    task automatic tick(input bit use_exp = 1'b0, input logic [15:0] exp_phase = '0);
        exp_t        e;
        int unsigned acc_new;
        int          sum;
        int          fbv;
        int          v;
        if (i_PhaseResetEnable) m_acc[i_PhaseResetAddr] = 0;
        if (i_Valid) begin
            v       = int'(i_VoiceOperator);
            acc_new = (m_acc[v] + m_step[v]) & 32'h00FF_FFFF;
            m_acc[v] = acc_new;
            sum     = m_fb0[v] + m_fb1[v];
            fbv     = (m_level[v] == 0) ? 0 : (sum >>> (9 - m_level[v]));
            e.phase = 16'((acc_new >> 8) + 32'(i_ModulationPhase) + 32'(fbv));
            if (use_exp) e.phase = exp_phase;
            e.vop   = i_VoiceOperator;
            e.alg   = i_AlgorithmWord;
            e.cyc   = cyc + 4;
            exp_q.push_back(e);
        end
        if (i_PhaseStepWriteEnable) m_step[i_PhaseStepWriteAddr] = 32'(i_PhaseStepWriteData);
        if (i_FeedbackLevelWriteEnable) m_level[i_FeedbackLevelWriteAddr] = int'(i_FeedbackLevelWriteData);
        if (i_FeedbackWriteEnable) begin
            m_fb1[i_FeedbackWriteAddr] = m_fb0[i_FeedbackWriteAddr];
            m_fb0[i_FeedbackWriteAddr] = int'($signed(i_FeedbackWriteData));
        end
        @(posedge i_Clock);
        #1;
        i_Valid                    = 1'b0;
        i_PhaseStepWriteEnable     = 1'b0;
        i_FeedbackLevelWriteEnable = 1'b0;
        i_PhaseResetEnable         = 1'b0;
        i_FeedbackWriteEnable      = 1'b0;
    endtask

    task automatic slot(input int vop, input logic [15:0] mod, input bit use_exp, input logic [15:0] exp_phase);
        i_Valid           = 1'b1;
        i_VoiceOperator   = VoiceOperatorID_t'(vop);
        i_ModulationPhase = mod;
        i_AlgorithmWord   = AlgorithmWord_t'($urandom);
        tick(use_exp, exp_phase);
    endtask

    task automatic write_step(input int vop, input logic [19:0] step);
        i_PhaseStepWriteEnable = 1'b1;
        i_PhaseStepWriteAddr   = VoiceOperatorID_t'(vop);
        i_PhaseStepWriteData   = step;
        tick();
    endtask

    // Monitor: pops on every valid output, flags unexpected and overdue ones.
    initial begin
        exp_t e;
        forever begin
            @(negedge i_Clock);
            if (i_Reset_n) begin
                if (o_Valid) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_valid: got o_Valid=1 with vop %0d, expected no output (cycle %0d)", o_VoiceOperator, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        check("phase",   32'(o_Phase), 32'(e.phase));
                        check("vop",     32'(o_VoiceOperator), 32'(e.vop));
                        check("alg",     32'(o_AlgorithmWord), 32'(e.alg));
                        check("latency", 32'(cyc), 32'(e.cyc));
                    end
                end else if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
                    e = exp_q.pop_front();
                    tests++;
                    fails++;
                    $display("FAIL missing_output: got none, expected phase 0x%0h due at cycle %0d", e.phase, e.cyc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned saved_acc12;
        int          a;
        for (int i = 0; i < NV; i++) begin
            m_acc[i] = 0; m_step[i] = 0; m_level[i] = 0; m_fb0[i] = 0; m_fb1[i] = 0;
        end

        #2 i_Reset_n = 1'b0;
        #10;
        check("rst_valid", 32'(o_Valid), 32'd0);
        check("rst_phase", 32'(o_Phase), 32'd0);
        check("rst_vop",   32'(o_VoiceOperator), 32'd0);
        check("rst_alg",   32'(o_AlgorithmWord), 32'd0);
        @(negedge i_Clock);
        i_Reset_n = 1'b1;
        @(posedge i_Clock);
        #1;

        // Software clear of all memories (two feedback writes flush the history pair).
        for (int i = 0; i < 2 * NV; i++) begin
            if (i < NV) begin
                i_PhaseStepWriteEnable = 1'b1;     i_PhaseStepWriteAddr = VoiceOperatorID_t'(i);     i_PhaseStepWriteData = '0;
                i_FeedbackLevelWriteEnable = 1'b1; i_FeedbackLevelWriteAddr = VoiceOperatorID_t'(i); i_FeedbackLevelWriteData = '0;
                i_PhaseResetEnable = 1'b1;         i_PhaseResetAddr = VoiceOperatorID_t'(i);
            end
            i_FeedbackWriteEnable = 1'b1; i_FeedbackWriteAddr = VoiceOperatorID_t'(i % NV); i_FeedbackWriteData = '0;
            tick();
        end

        // Steady stepping on vop 3, back to back.
        write_step(3, 20'h01000);
        for (int i = 1; i <= 5; i++) slot(3, 16'h0000, 1'b1, 16'(i * 16));

        // Accumulator wrap, then maximum positive modulation.
        write_step(4, 20'hFFF00);
        for (int i = 0; i < 16; i++) slot(4, 16'h0000, 1'b0, '0);
        write_step(4, 20'h02000);
        slot(4, 16'h0000, 1'b1, 16'h0010);
        write_step(4, 20'h00000);
        slot(4, 16'h7FFF, 1'b1, 16'h800F);

        // Back-to-back same operator exercises the write-back forward.
        write_step(5, 20'h00800);
        slot(5, 16'h0000, 1'b1, 16'h0008);
        slot(5, 16'h0000, 1'b1, 16'h0010);

        // Self-feedback: positive at level 7, negative at level 1.
        i_FeedbackLevelWriteEnable = 1'b1; i_FeedbackLevelWriteAddr = 1; i_FeedbackLevelWriteData = 3'd7;
        i_FeedbackWriteEnable = 1'b1; i_FeedbackWriteAddr = 1; i_FeedbackWriteData = 16'h4000;
        tick();
        i_FeedbackWriteEnable = 1'b1; i_FeedbackWriteAddr = 1; i_FeedbackWriteData = 16'h4000;
        tick();
        slot(1, 16'h0000, 1'b1, 16'h2000);
        i_FeedbackLevelWriteEnable = 1'b1; i_FeedbackLevelWriteAddr = 6; i_FeedbackLevelWriteData = 3'd1;
        i_FeedbackWriteEnable = 1'b1; i_FeedbackWriteAddr = 6; i_FeedbackWriteData = 16'h8000;
        tick();
        i_FeedbackWriteEnable = 1'b1; i_FeedbackWriteAddr = 6; i_FeedbackWriteData = 16'h8000;
        tick();
        slot(6, 16'h0000, 1'b1, 16'hFF00);

        // Phase reset colliding with write-back: with a same-op slot, then alone.
        write_step(2, 20'h01000);
        slot(2, 16'h0000, 1'b1, 16'h0010);
        i_PhaseResetEnable = 1'b1; i_PhaseResetAddr = 2;
        slot(2, 16'h0000, 1'b1, 16'h0010);
        tick();
        slot(2, 16'h0000, 1'b1, 16'h0020);
        slot(2, 16'h0000, 1'b1, 16'h0030);
        i_PhaseResetEnable = 1'b1; i_PhaseResetAddr = 2;
        tick();
        slot(2, 16'h0000, 1'b1, 16'h0010);

        // Reset with three slots in flight: 9 is delivered, 10/11 written back, 12 flushed.
        for (int i = 9; i <= 12; i++) write_step(i, 20'h00400);
        repeat (6) tick();
        slot(9, 16'h1234, 1'b0, '0);
        slot(10, 16'h0000, 1'b0, '0);
        slot(11, 16'h0000, 1'b0, '0);
        saved_acc12 = m_acc[12];
        slot(12, 16'h0000, 1'b0, '0);
        @(negedge i_Clock);
        #1;
        i_Reset_n = 1'b0;
        #1;
        check("flush_valid", 32'(o_Valid), 32'd0);
        check("flush_phase", 32'(o_Phase), 32'd0);
        check("flush_vop",   32'(o_VoiceOperator), 32'd0);
        check("flush_alg",   32'(o_AlgorithmWord), 32'd0);
        exp_q.delete();
        m_acc[12] = saved_acc12;
        repeat (2) @(posedge i_Clock);
        #2;
        i_Reset_n = 1'b1;
        @(posedge i_Clock);
        #1;
        for (int i = 0; i < 6; i++) begin
            check("no_stale_valid", 32'(o_Valid), 32'd0);
            tick();
        end
        slot(12, 16'h0000, 1'b1, 16'h0004);
        slot(11, 16'h0000, 1'b1, 16'h0008);
        slot(10, 16'h0000, 1'b0, '0);

        // Randomized traffic over a small operator set to provoke collisions.
        for (int i = 0; i < 400; i++) begin
            i_Valid           = ($urandom_range(0, 3) != 0);
            i_VoiceOperator   = VoiceOperatorID_t'($urandom_range(0, 7));
            i_ModulationPhase = 16'($urandom);
            i_AlgorithmWord   = AlgorithmWord_t'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                i_PhaseStepWriteEnable = 1'b1;
                i_PhaseStepWriteAddr   = VoiceOperatorID_t'($urandom_range(0, 7));
                i_PhaseStepWriteData   = 20'($urandom);
            end
            if ($urandom_range(0, 7) == 0) begin
                i_FeedbackLevelWriteEnable = 1'b1;
                i_FeedbackLevelWriteAddr   = VoiceOperatorID_t'($urandom_range(0, 7));
                i_FeedbackLevelWriteData   = FeedbackLevel_t'($urandom_range(0, 7));
            end
            if ($urandom_range(0, 3) == 0) begin
                i_FeedbackWriteEnable = 1'b1;
                i_FeedbackWriteAddr   = VoiceOperatorID_t'($urandom_range(0, 7));
                i_FeedbackWriteData   = 16'($urandom);
            end
            if ($urandom_range(0, 9) == 0) begin
                a = $urandom_range(0, 7);
                // A clear aimed at this cycle's own slot has no single sequential meaning; skip it.
                if (!(i_Valid && a == int'(i_VoiceOperator))) begin
                    i_PhaseResetEnable = 1'b1;
                    i_PhaseResetAddr   = VoiceOperatorID_t'(a);
                end
            end
            tick();
        end

        repeat (8) tick();
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
